dp_sram_arbiter: RTL and testbench

//  Shares one double-port TSMC SRAM macro (1 write port, 1 read port, 1-cycle read latency) between
//  NUM_WRITERS write requesters and NUM_READERS read requesters. Two independent round-robin arbiters

---
 rtl/dp_sram_ctrl_pkg.sv | 11 +
 rtl/dp_sram_arbiter_rr_arbiter.sv | 50 +++++
 rtl/dp_sram_arbiter.sv | 129 ++++++++++++
 tb/tb_dp_sram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_sram_ctrl_pkg.sv
// Shared constants and helpers for the double-port SRAM arbiter.
package dp_sram_ctrl_pkg;

  localparam int unsigned RrPtrReset = 0;

  // Index width that stays legal for a single requester.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dp_sram_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, pointer moves past the winner on advance.
module rr_arbiter
  import dp_sram_ctrl_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IdxWidth = clog2_min1(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                advance,
  output logic [N-1:0]        grant,
  output logic [IdxWidth-1:0] grant_idx
);

  logic [IdxWidth-1:0] ptr_q, ptr_d;
  logic                found;
  int unsigned         cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = (32'(ptr_q) + k) % N;
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = IdxWidth'(cand);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = IdxWidth'((32'(grant_idx) + 1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IdxWidth'(RrPtrReset);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dp_sram_arbiter.sv
// Shares one 1W/1R SRAM macro between several writers and readers; tagged read responses
// with backpressure, holding the macro's Q while the consumer stalls.
module dp_sram_arbiter
  import dp_sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned NUM_ROWS    = 4096,
  parameter int unsigned NUM_WRITERS = 2,
  parameter int unsigned NUM_READERS = 2,
  parameter bit          RAW_STALL   = 1'b1,
  localparam int unsigned AW         = $clog2(NUM_ROWS),
  localparam int unsigned IdWidth    = clog2_min1(NUM_READERS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_WRITERS-1:0]            wr_valid,
  output logic [NUM_WRITERS-1:0]            wr_ready,
  input  logic [NUM_WRITERS-1:0][AW-1:0]    wr_addr,
  input  logic [NUM_WRITERS-1:0][WIDTH-1:0] wr_data,
  input  logic [NUM_WRITERS-1:0][WIDTH-1:0] wr_bit_en,
  input  logic [NUM_READERS-1:0]            rd_valid,
  output logic [NUM_READERS-1:0]            rd_ready,
  input  logic [NUM_READERS-1:0][AW-1:0]    rd_addr,
  output logic                              rsp_valid,
  output logic [IdWidth-1:0]                rsp_id,
  output logic [WIDTH-1:0]                  rsp_data,
  input  logic                              rsp_ready,
  output logic                              sram_reb,
  output logic                              sram_web,
  output logic [AW-1:0]                     sram_aa,
  output logic [AW-1:0]                     sram_ab,
  output logic [WIDTH-1:0]                  sram_d,
  output logic [WIDTH-1:0]                  sram_m,
  input  logic [WIDTH-1:0]                  sram_q
);

  localparam int unsigned WrIdxWidth = clog2_min1(NUM_WRITERS);

  logic [NUM_WRITERS-1:0] wr_req, wr_gnt;
  logic [WrIdxWidth-1:0]  wr_idx;
  logic [NUM_READERS-1:0] rd_req, rd_gnt;
  logic [IdWidth-1:0]     rd_idx;
  logic                   issue_ok, raw_hit, rd_stall, rd_issue, wr_issue;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [IdWidth-1:0]     id_q, id_d;

  always_comb begin
    wr_req   = rst ? '0 : wr_valid;
    // A held response must not lose its Q, so no read issues until it is consumed.
    issue_ok = !rsp_valid_q || rsp_ready;
    rd_req   = (rst || !issue_ok) ? '0 : rd_valid;
  end

  rr_arbiter #(
    .N (NUM_WRITERS)
  ) u_wr_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (wr_req),
    .advance   (|wr_gnt),
    .grant     (wr_gnt),
    .grant_idx (wr_idx)
  );

  rr_arbiter #(
    .N (NUM_READERS)
  ) u_rd_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (rd_req),
    .advance   (rd_issue),
    .grant     (rd_gnt),
    .grant_idx (rd_idx)
  );

  always_comb begin
    wr_issue = |wr_gnt;
    raw_hit  = wr_issue && (|rd_gnt) && (wr_addr[wr_idx] == rd_addr[rd_idx]);
    rd_stall = RAW_STALL && raw_hit;
    rd_ready = rd_stall ? '0 : rd_gnt;
    rd_issue = |rd_ready;
    wr_ready = wr_gnt;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    id_d        = id_q;
    if (rd_issue) begin
      rsp_valid_d = 1'b1;
      id_d        = rd_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      id_q        <= id_d;
    end
  end

  always_comb begin
    sram_web = 1'b1;
    sram_aa  = '0;
    sram_d   = '0;
    sram_m   = '0;
    sram_reb = 1'b1;
    sram_ab  = '0;
    if (wr_issue) begin
      sram_web = 1'b0;
      sram_aa  = wr_addr[wr_idx];
      sram_d   = wr_data[wr_idx];
      sram_m   = ~wr_bit_en[wr_idx];
    end
    if (rd_issue) begin
      sram_reb = 1'b0;
      sram_ab  = rd_addr[rd_idx];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = sram_q;

endmodule

// File: tb/tb_dp_sram_arbiter.sv
// Directed bench: one arbiter with RAW stalling, one without, each on its own SRAM model.
module tb_dp_sram_arbiter;

  localparam int W  = 128;
  localparam int AW = 12;

  localparam logic [W-1:0] DAa = {16{8'hAA}};
  localparam logic [W-1:0] DFf = {128{1'b1}};
  localparam logic [W-1:0] B0f = {16{8'h0F}};
  localparam logic [W-1:0] MF0 = {16{8'hF0}};
  localparam logic [W-1:0] DAf = {16{8'hAF}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst;
  logic [1:0]            wr_valid, rd_valid;
  logic [1:0][AW-1:0]    wr_addr, rd_addr;
  logic [1:0][W-1:0]     wr_data, wr_bit_en;
  logic                  rsp_ready;

  logic [1:0]    wr_ready_s, rd_ready_s, wr_ready_n, rd_ready_n;
  logic          rsp_valid_s, rsp_valid_n, rsp_id_s, rsp_id_n;
  logic [W-1:0]  rsp_data_s, rsp_data_n;
  logic          reb_s, web_s, reb_n, web_n;
  logic [AW-1:0] aa_s, ab_s, aa_n, ab_n;
  logic [W-1:0]  d_s, m_s, q_s, d_n, m_n, q_n;

  dp_sram_arbiter #(.RAW_STALL(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready_s), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bit_en(wr_bit_en), .rd_valid(rd_valid), .rd_ready(rd_ready_s), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid_s), .rsp_id(rsp_id_s), .rsp_data(rsp_data_s), .rsp_ready(rsp_ready),
    .sram_reb(reb_s), .sram_web(web_s), .sram_aa(aa_s), .sram_ab(ab_s), .sram_d(d_s),
    .sram_m(m_s), .sram_q(q_s)
  );

  dp_sram_arbiter #(.RAW_STALL(1'b0)) u_dut_nostall (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready_n), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_bit_en(wr_bit_en), .rd_valid(rd_valid), .rd_ready(rd_ready_n), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid_n), .rsp_id(rsp_id_n), .rsp_data(rsp_data_n), .rsp_ready(rsp_ready),
    .sram_reb(reb_n), .sram_web(web_n), .sram_aa(aa_n), .sram_ab(ab_n), .sram_d(d_n),
    .sram_m(m_n), .sram_q(q_n)
  );

  logic [W-1:0] mem_s [4096];
  logic [W-1:0] mem_n [4096];

  // Macro model: read returns pre-edge contents; mask bit 1 keeps the stored bit.
  always @(posedge clk) begin
    if (!reb_s) q_s <= mem_s[ab_s];
    if (!web_s) mem_s[aa_s] <= (mem_s[aa_s] & m_s) | (d_s & ~m_s);
    if (!reb_n) q_n <= mem_n[ab_n];
    if (!web_n) mem_n[aa_n] <= (mem_n[aa_n] & m_n) | (d_n & ~m_n);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_valid  = '0;
    rd_valid  = '0;
    wr_addr   = '0;
    rd_addr   = '0;
    wr_data   = '0;
    wr_bit_en = '0;
    rsp_ready = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset holds every grant and SRAM enable off.
    @(negedge clk);
    wr_valid = 2'b11;
    rd_valid = 2'b11;
    #1;
    check("rst_wr_ready", wr_ready_s, 0);
    check("rst_rd_ready", rd_ready_s, 0);
    check("rst_reb", reb_s, 1);
    check("rst_web", web_s, 1);
    check("rst_rsp_valid", rsp_valid_s, 0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Full write then read by reader 1.
    wr_valid     = 2'b01;
    wr_addr[0]   = 12'd5;
    wr_data[0]   = DAa;
    wr_bit_en[0] = DFf;
    #1;
    check("w_ready", wr_ready_s, 2'b01);
    check("w_web", web_s, 0);
    check("w_mask", m_s, 0);
    @(negedge clk);
    idle();
    rd_valid   = 2'b10;
    rd_addr[1] = 12'd5;
    #1;
    check("r_ready", rd_ready_s, 2'b10);
    check("r_reb", reb_s, 0);
    check("r_ab", ab_s, 5);
    @(posedge clk);
    #1;
    check("r_rsp_valid", rsp_valid_s, 1);
    check("r_rsp_id", rsp_id_s, 1);
    check("r_rsp_data", rsp_data_s, DAa);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check("r_rsp_clear", rsp_valid_s, 0);

    // Masked write: only low nibbles overwritten.
    @(negedge clk);
    wr_valid     = 2'b01;
    wr_addr[0]   = 12'd5;
    wr_data[0]   = DFf;
    wr_bit_en[0] = B0f;
    #1;
    check("mw_mask", m_s, MF0);
    @(negedge clk);
    idle();
    rd_valid   = 2'b01;
    rd_addr[0] = 12'd5;
    @(posedge clk);
    #1;
    check("mw_rsp_id", rsp_id_s, 0);
    check("mw_rsp_data", rsp_data_s, DAf);

    // Reset pointers, then full contention for four cycles.
    @(negedge clk);
    idle();
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    wr_valid   = 2'b11;
    rd_valid   = 2'b11;
    wr_addr[0] = 12'd20;
    wr_addr[1] = 12'd21;
    rd_addr[0] = 12'd30;
    rd_addr[1] = 12'd31;
    wr_bit_en  = {DFf, DFf};
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_wr%0d", i), wr_ready_s, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_rd%0d", i), rd_ready_s, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
    end

    // Backpressure: response from r0 held for three cycles.
    idle();
    rd_valid   = 2'b01;
    rd_addr[0] = 12'd5;
    @(posedge clk);
    @(negedge clk);
    rsp_ready  = 1'b0;
    rd_valid   = 2'b11;
    rd_addr[1] = 12'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_rd_ready%0d", i), rd_ready_s, 0);
      check($sformatf("bp_reb%0d", i), reb_s, 1);
      @(posedge clk);
      #1;
      check($sformatf("bp_valid%0d", i), rsp_valid_s, 1);
      check($sformatf("bp_id%0d", i), rsp_id_s, 0);
      check($sformatf("bp_data%0d", i), rsp_data_s, DAf);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", rd_ready_s, 2'b10);
    check("bp_release_reb", reb_s, 0);
    @(posedge clk);
    #1;
    check("bp_release_id", rsp_id_s, 1);
    check("bp_release_data", rsp_data_s, DAf);

    // RAW: addr 9 holds 1, then same-cycle write of 2 and read.
    @(negedge clk);
    idle();
    wr_valid     = 2'b01;
    wr_addr[0]   = 12'd9;
    wr_data[0]   = 128'h1;
    wr_bit_en[0] = DFf;
    @(negedge clk);
    wr_data[0] = 128'h2;
    rd_valid   = 2'b01;
    rd_addr[0] = 12'd9;
    #1;
    check("raw_stall_rd_ready", rd_ready_s, 0);
    check("raw_stall_reb", reb_s, 1);
    check("raw_stall_wr_ready", wr_ready_s, 2'b01);
    check("raw_nostall_rd_ready", rd_ready_n, 2'b01);
    @(posedge clk);
    #1;
    check("raw_stall_no_rsp", rsp_valid_s, 0);
    check("raw_nostall_valid", rsp_valid_n, 1);
    check("raw_nostall_data", rsp_data_n, 128'h1);
    @(negedge clk);
    wr_valid = '0;
    #1;
    check("raw_retry_ready", rd_ready_s, 2'b01);
    @(posedge clk);
    #1;
    check("raw_retry_valid", rsp_valid_s, 1);
    check("raw_retry_data", rsp_data_s, 128'h2);

    // Reset while a response is pending.
    @(negedge clk);
    idle();
    rsp_ready = 1'b0;
    rst       = 1'b1;
    wr_valid  = 2'b11;
    rd_valid  = 2'b11;
    #1;
    check("mrst_wr_ready", wr_ready_s, 0);
    check("mrst_rd_ready", rd_ready_s, 0);
    @(posedge clk);
    #1;
    check("mrst_rsp_valid", rsp_valid_s, 0);
    @(negedge clk);
    rst        = 1'b0;
    rd_valid   = '0;
    wr_addr[0] = 12'd50;
    wr_addr[1] = 12'd51;
    #1;
    check("mrst_first_wr", wr_ready_s, 2'b01);

    @(negedge clk);
    idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
